// File: rtl/inst_axi_bridge.sv
// Read-only bridge from the fetch stage's SRAM-like instruction port to a single-beat AXI read master.
// One fetch is in flight at a time; a cancelled fetch still completes on AXI but is never reported.
module inst_axi_bridge #(
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_rerr,
    input  logic        cancel,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_dv;
    logic        r_discard;
    logic        w_addrOk;
    logic        w_unused;

    // rid/rlast carry no information with a single outstanding one-beat burst
    assign w_unused = ^{rid, rlast, inst_sram_wr};

    assign w_addrOk = (r_state == S_IDLE) & inst_sram_en & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_addrOk) w_next = S_AR;
            S_AR:    if (arready)  w_next = S_R;
            S_R:     if (rvalid)   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // A cancel seen at any point after acceptance marks the fetch as discarded,
    // but the AXI beat is always consumed so the slave is never left hanging.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= 32'd0;
            r_size    <= 2'd0;
            r_rdata   <= 32'd0;
            r_err     <= 1'b0;
            r_dv      <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_addrOk) begin
                        r_addr    <= inst_sram_addr;
                        r_size    <= inst_sram_size;
                        r_discard <= 1'b0;
                    end
                end
                S_AR: begin
                    if (cancel) r_discard <= 1'b1;
                end
                S_R: begin
                    if (cancel) r_discard <= 1'b1;
                    if (rvalid) begin
                        r_rdata <= rdata;
                        r_err   <= |rresp;
                        r_dv    <= ~(r_discard | cancel);
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_sram_addr_ok = w_addrOk;
    assign inst_sram_data_ok = r_dv & ~cancel;
    assign inst_sram_rerr    = r_dv & r_err & ~cancel;
    assign inst_sram_rdata   = r_rdata;

    assign arid    = ARID_VAL;
    assign araddr  = r_addr;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, r_size};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (r_state == S_AR);
    assign rready  = (r_state == S_R);

    // Writes have no path through this bridge
    wrIsIllegal: assert property (@(posedge clk) disable iff (reset)
        inst_sram_en |-> !inst_sram_wr);

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Scoreboard bench for inst_axi_bridge: directed fetches push expected words, a monitor
// pops them whenever data_ok is presented, and the stimulus tasks also check cycle timing.
module tb_inst_axi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addrIn;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] rdataOut;
    logic        rerr;
    logic        cancel;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdataIn;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t expQ[$];

    inst_axi_bridge #(.ARID_VAL(4'd0)) dut (
        .clk               (clk),
        .reset             (reset),
        .inst_sram_en      (en),
        .inst_sram_wr      (wr),
        .inst_sram_size    (size),
        .inst_sram_addr    (addrIn),
        .inst_sram_addr_ok (addrOk),
        .inst_sram_data_ok (dataOk),
        .inst_sram_rdata   (rdataOut),
        .inst_sram_rerr    (rerr),
        .cancel            (cancel),
        .arid              (arid),
        .araddr            (araddr),
        .arlen             (arlen),
        .arsize            (arsize),
        .arburst           (arburst),
        .arlock            (arlock),
        .arcache           (arcache),
        .arprot            (arprot),
        .arvalid           (arvalid),
        .arready           (arready),
        .rid               (rid),
        .rdata             (rdataIn),
        .rresp             (rresp),
        .rlast             (rlast),
        .rvalid            (rvalid),
        .rready            (rready)
    );

    // 10 ns clock; inputs change 1 ns after the rising edge, outputs sampled on the falling edge
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one fetch through the AXI handshakes with chosen stalls. 'accepted' means the
    // request was already taken in the previous data_ok cycle; lateCancel/nextEn act in this
    // fetch's own data_ok cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                                 input int arWait, input int rWait, input bit cancelR, input bit deliver,
                                 input bit accepted, input bit lateCancel, input bit nextEn,
                                 input logic [31:0] nextAddr);
        if (deliver) expQ.push_back('{data, (resp != 2'b00)});
        if (!accepted) begin
            en = 1'b1;
            addrIn = addr;
            @(negedge clk);
            checkOutput("addr_ok on request", {31'd0, addrOk}, 32'd1);
            checkOutput("arvalid in request cycle", {31'd0, arvalid}, 32'd0);
            nextCycle();
        end
        addrIn = 32'h0;
        for (int i = 0; i < arWait; i++) begin
            en = 1'b1;
            arready = 1'b0;
            @(negedge clk);
            checkOutput("arvalid held", {31'd0, arvalid}, 32'd1);
            checkOutput("araddr held", araddr, addr);
            checkOutput("addr_ok busy in AR", {31'd0, addrOk}, 32'd0);
            nextCycle();
        end
        en = 1'b0;
        arready = 1'b1;
        @(negedge clk);
        checkOutput("arvalid at handshake", {31'd0, arvalid}, 32'd1);
        checkOutput("araddr", araddr, addr);
        checkOutput("arsize", {29'd0, arsize}, 32'd2);
        checkOutput("arlen", {24'd0, arlen}, 32'd0);
        checkOutput("arburst", {30'd0, arburst}, 32'd1);
        checkOutput("rready in AR", {31'd0, rready}, 32'd0);
        nextCycle();
        arready = 1'b0;
        for (int i = 0; i < rWait; i++) begin
            en = 1'b1;
            cancel = cancelR && (i == 0);
            rvalid = 1'b0;
            @(negedge clk);
            checkOutput("rready waiting", {31'd0, rready}, 32'd1);
            checkOutput("arvalid in R", {31'd0, arvalid}, 32'd0);
            checkOutput("addr_ok busy in R", {31'd0, addrOk}, 32'd0);
            nextCycle();
            cancel = 1'b0;
        end
        en = 1'b0;
        cancel = cancelR && (rWait == 0);
        rvalid = 1'b1;
        rdataIn = data;
        rresp = resp;
        @(negedge clk);
        checkOutput("rready at handshake", {31'd0, rready}, 32'd1);
        checkOutput("data_ok before capture", {31'd0, dataOk}, 32'd0);
        nextCycle();
        rvalid = 1'b0;
        rdataIn = 32'h0;
        rresp = 2'b00;
        cancel = lateCancel;
        en = nextEn;
        addrIn = nextAddr;
        @(negedge clk);
        checkOutput("data_ok after R handshake", {31'd0, dataOk}, {31'd0, deliver});
        checkOutput("rerr after R handshake", {31'd0, rerr}, {31'd0, deliver && (resp != 2'b00)});
        checkOutput("rdata captured", rdataOut, data);
        if (nextEn) checkOutput("addr_ok alongside data_ok", {31'd0, addrOk}, 32'd1);
        nextCycle();
        cancel = 1'b0;
        en = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && dataOk) begin
            if (expQ.size() == 0) begin
                checkOutput("data_ok with empty scoreboard", {31'd0, dataOk}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("scoreboard rdata", rdataOut, e.data);
                checkOutput("scoreboard rerr", {31'd0, rerr}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en = 1'b1;
        wr = 1'b0;
        size = 2'b10;
        addrIn = 32'hbfc00000;
        cancel = 1'b0;
        arready = 1'b0;
        rid = 4'd0;
        rdataIn = 32'h0;
        rresp = 2'b00;
        rlast = 1'b1;
        rvalid = 1'b0;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset addr_ok", {31'd0, addrOk}, 32'd0);
        checkOutput("reset arvalid", {31'd0, arvalid}, 32'd0);
        checkOutput("reset rready", {31'd0, rready}, 32'd0);
        checkOutput("reset data_ok", {31'd0, dataOk}, 32'd0);
        checkOutput("reset rdata", rdataOut, 32'd0);
        checkOutput("reset rerr", {31'd0, rerr}, 32'd0);
        checkOutput("reset araddr", araddr, 32'd0);
        nextCycle();
        reset = 1'b0;
        en = 1'b0;
        nextCycle();

        $display("[TB] single fetch");
        applyStimulus(32'hbfc00000, 32'h3c1d0001, 2'b00, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("data_ok one cycle only", {31'd0, dataOk}, 32'd0);
        nextCycle();

        $display("[TB] back-pressure");
        applyStimulus(32'hbfc00004, 32'h24080005, 2'b00, 3, 5, 0, 1, 0, 0, 0, 32'h0);

        $display("[TB] cancel in R");
        applyStimulus(32'hbfc00100, 32'h11111111, 2'b00, 0, 2, 1, 0, 0, 0, 0, 32'h0);
        applyStimulus(32'hbfc00380, 32'h8c080000, 2'b00, 0, 0, 0, 1, 0, 0, 0, 32'h0);

        $display("[TB] cancel with new request");
        applyStimulus(32'hbfc00010, 32'h22222222, 2'b00, 0, 0, 0, 0, 0, 1, 1, 32'hbfc00014);
        applyStimulus(32'hbfc00014, 32'h33333333, 2'b00, 1, 1, 0, 1, 1, 0, 0, 32'h0);

        $display("[TB] back-to-back");
        applyStimulus(32'hbfc00020, 32'h44444444, 2'b00, 0, 0, 0, 1, 0, 0, 1, 32'hbfc00024);
        applyStimulus(32'hbfc00024, 32'h55555555, 2'b00, 0, 0, 0, 1, 1, 0, 0, 32'h0);

        $display("[TB] error response");
        applyStimulus(32'hbfc00030, 32'hdeadbeef, 2'b10, 0, 0, 0, 1, 0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("rerr one cycle only", {31'd0, rerr}, 32'd0);
        checkOutput("rdata held after error", rdataOut, 32'hdeadbeef);
        nextCycle();

        $display("[TB] reset mid-AR");
        en = 1'b1;
        addrIn = 32'hbfc00040;
        @(negedge clk);
        checkOutput("addr_ok before reset", {31'd0, addrOk}, 32'd1);
        nextCycle();
        en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("arvalid before reset edge", {31'd0, arvalid}, 32'd1);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("arvalid after reset", {31'd0, arvalid}, 32'd0);
        checkOutput("rready after reset", {31'd0, rready}, 32'd0);
        checkOutput("data_ok after reset", {31'd0, dataOk}, 32'd0);
        nextCycle();
        applyStimulus(32'hbfc00050, 32'h66666666, 2'b00, 0, 1, 0, 1, 0, 0, 0, 32'h0);

        repeat (3) nextCycle();
        checkOutput("scoreboard drained", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_axi_bridge.md
# inst_axi_bridge

Read-only bridge between the fetch stage's SRAM-like instruction port and an AXI read master port. It sits directly upstream of the IF stage. It accepts one fetch request at a time (`en`/`addr_ok`), issues a single-beat AXI read, and returns the word with a one-cycle `data_ok` pulse. A `cancel` input lets the pipeline drop an in-flight fetch on exception or ERET redirect without violating AXI.

## Interface
- `ARID_VAL`, default 4'd0: constant driven on `arid`.
- `clk`  in  1: clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `inst_sram_en`  in  1: fetch request valid.
- `inst_sram_wr`  in  1: must be 0. Ignored; the block is read-only.
- `inst_sram_size`  in  2: log2 bytes; fetch uses 2'b10.
- `inst_sram_addr`  in  32: word-aligned fetch address.
- `inst_sram_addr_ok`  out  1: request accepted this cycle.
- `inst_sram_data_ok`  out  1: one-cycle pulse; `inst_sram_rdata` valid.
- `inst_sram_rdata`  out  32: returned instruction word (registered).
- `inst_sram_rerr`  out  1: pulses with `data_ok` when `rresp != 0`.
- `cancel`  in  1: discard the outstanding fetch, if any.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3, `arvalid` out 1, `arready` in 1: AXI AR channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI R channel.

## Operation
- States: IDLE, AR (address issued), R (awaiting data). Reset state is IDLE.
- `inst_sram_addr_ok = (state==IDLE) & inst_sram_en & ~reset`. This path is combinational so the IF stage sees acceptance in the request cycle.
- IDLE, when `addr_ok`: latch `addr` into `addr_r` and `size` into `size_r`, clear `discard`, go to AR.
- AR: `arvalid=1`, `araddr=addr_r`, `arsize={1'b0,size_r}`. Constants are `arlen=0`, `arburst=2'b01`, `arlock=0`, `arcache=0`, `arprot=0`, `arid=ARID_VAL`. `arvalid` and `araddr` are held stable until `arready`. On `arvalid&arready`, go to R.
- R: `rready=1`. On `rvalid&rready`, capture `rdata` into `rdata_r` and `rresp!=0` into `err_r`. If `~discard`, set `dv_r`. Go to IDLE.
- Outputs: `inst_sram_data_ok = dv_r` and `inst_sram_rerr = dv_r & err_r`. `dv_r` self-clears after one cycle. `inst_sram_rdata = rdata_r`, held until the next capture.
- `rid` and `rlast` are ignored: there is a single outstanding transaction and `arlen=0`.
- `arvalid`/`rready` outside AR/R: 0.
- `cancel`:
  - In AR or R, or on an R-handshake cycle: sets `discard`. AR still completes and the R beat is still consumed, but `data_ok` is not raised.
  - In IDLE with no pending `dv_r`: no effect.
  - In the same cycle as `dv_r=1`: suppresses that `data_ok`, so `data_ok` is gated with `~cancel`.
  - `cancel` and `addr_ok` in the same cycle: the new request is accepted and is not discarded. `cancel` applies to older transactions only.
- `inst_sram_wr=1`: treated as a read. This is illegal stimulus; assert-check it in simulation.

## Timing
- Reset values (next edge after `reset=1`): state=IDLE, `arvalid=0`, `rready=0`, `dv_r=0`, `err_r=0`, `discard=0`, `rdata_r=0`, `addr_r=0`. `addr_ok` is 0 during reset.
- Reset mid-transaction returns to IDLE immediately. The system must reset the AXI slave in the same cycle.
- Minimum latency, with `arready` and `rvalid` both 1 in the first cycle of their state:
  - cycle 0: `addr_ok`.
  - cycle 1: AR handshake.
  - cycle 2: R handshake.
  - cycle 3: `data_ok`.
- `data_ok` and a new `addr_ok` may be high in the same cycle (state is IDLE while `dv_r` is set). Back-to-back fetches therefore sustain one word per 3 cycles.
- At most one transaction is outstanding. `addr_ok` is never high while in AR or R.
- `arvalid` never drops before `arready`. Every issued AR receives exactly one R handshake before IDLE.

## Test plan
- Single fetch: `en=1`, `addr=0xbfc00000`, `arready=1`, `rvalid=1` with `rdata=0x3c1d0001`, `rresp=0` -> `addr_ok` at cycle 0, `araddr=0xbfc00000` with `arsize=3'b010` at cycle 1, `data_ok=1` with `rdata=0x3c1d0001` and `rerr=0` at cycle 3 only.
- Back-pressure: `arready` low 3 cycles, `rvalid` low 5 cycles -> `arvalid` and `araddr` stable throughout, `addr_ok` stays 0 while busy, `data_ok` exactly once, 1 cycle after the R handshake.
- Cancel in R: `cancel` pulsed the cycle after the AR handshake; `rvalid` arrives 2 cycles later -> `rready` handshake occurs, `data_ok` stays 0, next `en` (`addr=0xbfc00380`) is accepted in IDLE and returns its own data normally.
- Cancel with new request: `cancel=1` and `en=1` in the same IDLE cycle that `dv_r=1` -> old `data_ok` suppressed, new request accepted, and its `data_ok` is delivered.
- Error response: `rresp=2'b10`, `rdata=0xdeadbeef` -> `data_ok=1`, `rerr=1`, `rdata=0xdeadbeef` for one cycle.
- Reset mid-AR: assert `reset` while `arvalid=1` -> next cycle `arvalid=0`, `rready=0`, `data_ok=0`, state IDLE, and a subsequent fetch completes normally.
